regfile_wb_ctrl: RTL and testbench
==================================

# regfile_wb_ctrl

Write-back controller for the integer register file. It shares the register file's single write port between the execute stage and the load/store unit using round-robin arbitration, and registers the granted write onto the port. It also keeps a per-register pending-load scoreboard that drives a read-after-write stall to decode. It sits between EX/LSU and `regfiles`, alongside the decode read ports.

## Interface
Parameters:
- `CNT_W`, 16: width of the arbitration-conflict counter.
- `XLEN`, `REG_NUM`: taken from `defines.v`, not overridable here.

Ports:
- `clk_i`  in  1  system clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `ex_wb_valid_i`  in  1  EX write-back request.
- `ex_wb_addr_i`  in  5  EX destination register.
- `ex_wb_data_i`  in  XLEN  EX result.
- `ex_wb_ready_o`  out  1  EX request accepted this cycle.
- `lsu_wb_valid_i`  in  1  LSU load-data write-back request.
- `lsu_wb_addr_i`  in  5  LSU destination register.
- `lsu_wb_data_i`  in  XLEN  load data.
- `lsu_wb_ready_o`  out  1  LSU request accepted this cycle.
- `lsu_issue_i`  in  1  load issued to LSU; marks its destination pending.
- `lsu_issue_addr_i`  in  5  destination of the issued load.
- `rs1_addr_i`, `rs2_addr_i`  in  5 each  decode source addresses.
- `hazard_o`  out  1  decode must stall: a source register is pending.
- `rd_we_o`  out  1  register-file write enable.
- `rd_addr_o`  out  5  register-file write address.
- `rd_data_o`  out  XLEN  register-file write data.
- `conflict_cnt_o`  out  CNT_W  saturating count of cycles in which both requesters were valid.

## Operation
- Handshake: a request transfers when valid and ready are both high in the same cycle. Ready is combinational from the valids and the arbiter state. At most one ready is high per cycle.
- Arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not granted last grants. `last_lsu` flop updates on every transfer.
  - Reset state: `last_lsu`=1, so EX wins the first tie.
- Output register: on a transfer, `rd_addr_o`/`rd_data_o` load the granted address and data. `rd_we_o` loads 1 unless the address is 0; a write to x0 is accepted but never asserts `rd_we_o`. With no transfer, `rd_we_o` loads 0 and `rd_addr_o`/`rd_data_o` hold their values.
- Scoreboard `pend[REG_NUM-1:0]`:
  - Set on `lsu_issue_i` for `lsu_issue_addr_i`, if nonzero.
  - Cleared on the edge where `rd_we_o`=1 and the write originated from the LSU (tracked by a registered `wb_src_lsu` flag).
  - Simultaneous set and clear of the same bit: set wins.
  - `pend[0]` is constant 0.
- `hazard_o` = `pend[rs1_addr_i] | pend[rs2_addr_i]`, combinational.
- EX writes never touch the scoreboard.
- Conflict counter: increments when both valids are high, saturates at all-ones, and never wraps.
- Reset mid-operation: all state clears immediately and asynchronously. A request in flight is dropped; the requester re-presents it after reset.

## Timing
- Reset values:
  - `rd_we_o`=0, `rd_addr_o`=0, `rd_data_o`=0.
  - `ex_wb_ready_o`/`lsu_wb_ready_o` follow the inputs (0 when the valids are 0).
  - `hazard_o`=0, `conflict_cnt_o`=0, `pend`=0, `last_lsu`=1.
- Write latency:
  - Request accepted at edge N.
  - `rd_*` valid during cycle N..N+1; the register file writes at edge N+1.
- Scoreboard timing:
  - A pending bit set at edge N raises `hazard_o` from cycle N onward.
  - A load write-back accepted at edge N clears its bit at edge N+1.
  - `hazard_o` therefore deasserts in the cycle after the register file holds the data; no bypass is needed.
- Throughput: one write per cycle. Under continuous contention, grants alternate EX, LSU, EX, and so on.

## Structure
- The write-back source encoding (`WB_SRC_EX`=0, `WB_SRC_LSU`=1) and `CNT_W` default belong in the shared package / `defines.v`, next to `XLEN` and `REG_NUM`.
- Sub-module `wb_rr_arb2`: 2-way round-robin arbiter holding `last_lsu`, producing the grants and the transfer strobe.
- The scoreboard, output register and counter stay in the top level.

## Test plan
- EX only: EX valid, addr 5, data 0x1234 → `ex_wb_ready_o`=1; next cycle `rd_we_o`=1, `rd_addr_o`=5, `rd_data_o`=0x1234, then `rd_we_o`=0.
- Tie after reset: both valid for 3 cycles (EX addr 1, LSU addr 2) → grants go EX, LSU, EX; `conflict_cnt_o`=3.
- Scoreboard round trip:
  - `lsu_issue_i` addr 7, then `rs1_addr_i`=7 → `hazard_o`=1.
  - LSU write-back addr 7 accepted at edge N → `hazard_o`=1 in cycle N..N+1, 0 after edge N+1.
- x0 handling:
  - EX write to addr 0 → accepted, `rd_we_o` stays 0.
  - `lsu_issue_i` addr 0 with `rs2_addr_i`=0 → `hazard_o`=0.
- Set/clear collision: LSU write-back of addr 9 clears `pend[9]` on the same edge as a new issue to addr 9 → `pend[9]` remains 1 and `hazard_o` stays high for reads of x9.
- Async reset mid-stream: `rst_i` pulsed between edges with `pend` nonzero and `rd_we_o`=1 → all outputs at reset values immediately; first post-reset tie is granted to EX.

Source files
------------

// File: rtl/regfile_wb_ctrl_pkg.sv
// rtl/regfile_wb_ctrl_pkg.sv - shared widths and write-back source encoding for the write-back controller
package regfile_wb_ctrl_pkg;

    localparam int XLEN      = 32;
    localparam int REG_NUM   = 32;
    localparam int REG_AW    = 5;
    localparam int CNT_W_DEF = 16;

    typedef enum logic {
        WB_SRC_EX  = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_rr_arb2.sv
// rtl/wb_rr_arb2.sv - two-way round-robin arbiter between EX and LSU write-back requests
module wb_rr_arb2
    import regfile_wb_ctrl_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic ex_valid_i,
    input  logic lsu_valid_i,
    output logic ex_grant_o,
    output logic lsu_grant_o,
    output logic xfer_o
);

    // Reset to 1 so that EX wins the first tie after reset.
    logic last_lsu;

    // Grants are combinational; a lone requester always wins, a tie goes to whoever did not win last.
    always_comb begin
        ex_grant_o  = ex_valid_i  & (~lsu_valid_i | last_lsu);
        lsu_grant_o = lsu_valid_i & (~ex_valid_i  | ~last_lsu);
        xfer_o      = ex_grant_o | lsu_grant_o;
    end

    // Remember the winner of every transfer, tie or not.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_lsu <= 1'b1;
        end else if (xfer_o) begin
            last_lsu <= lsu_grant_o;
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// rtl/regfile_wb_ctrl.sv - register-file write-port arbiter, output register and pending-load scoreboard
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ex_wb_valid_i,
    input  logic [REG_AW-1:0] ex_wb_addr_i,
    input  logic [XLEN-1:0]   ex_wb_data_i,
    output logic              ex_wb_ready_o,
    input  logic              lsu_wb_valid_i,
    input  logic [REG_AW-1:0] lsu_wb_addr_i,
    input  logic [XLEN-1:0]   lsu_wb_data_i,
    output logic              lsu_wb_ready_o,
    input  logic              lsu_issue_i,
    input  logic [REG_AW-1:0] lsu_issue_addr_i,
    input  logic [REG_AW-1:0] rs1_addr_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    output logic              hazard_o,
    output logic              rd_we_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic [XLEN-1:0]   rd_data_o,
    output logic [CNT_W-1:0]  conflict_cnt_o
);

    logic              ex_grant;
    logic              lsu_grant;
    logic              xfer;
    logic [REG_AW-1:0] sel_addr;
    logic [XLEN-1:0]   sel_data;
    wb_src_e           wb_src;
    logic [REG_NUM-1:0] pend;
    logic [REG_NUM-1:0] pend_nxt;

    wb_rr_arb2 u_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .ex_valid_i  (ex_wb_valid_i),
        .lsu_valid_i (lsu_wb_valid_i),
        .ex_grant_o  (ex_grant),
        .lsu_grant_o (lsu_grant),
        .xfer_o      (xfer)
    );

    // Ready is simply the grant, so at most one requester sees ready per cycle.
    always_comb begin
        ex_wb_ready_o  = ex_grant;
        lsu_wb_ready_o = lsu_grant;
        sel_addr       = lsu_grant ? lsu_wb_addr_i : ex_wb_addr_i;
        sel_data       = lsu_grant ? lsu_wb_data_i : ex_wb_data_i;
    end

    // Register the granted write onto the port; x0 writes are accepted but never enabled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_we_o   <= 1'b0;
            rd_addr_o <= '0;
            rd_data_o <= '0;
            wb_src    <= WB_SRC_EX;
        end else if (xfer) begin
            rd_we_o   <= (sel_addr != '0);
            rd_addr_o <= sel_addr;
            rd_data_o <= sel_data;
            wb_src    <= lsu_grant ? WB_SRC_LSU : WB_SRC_EX;
        end else begin
            rd_we_o   <= 1'b0;
        end
    end

    // Next scoreboard: clear on the LSU write reaching the port, set on issue; set wins, x0 never pends.
    always_comb begin
        pend_nxt = pend;
        if (rd_we_o && (wb_src == WB_SRC_LSU)) begin
            pend_nxt[rd_addr_o] = 1'b0;
        end
        if (lsu_issue_i && (lsu_issue_addr_i != '0)) begin
            pend_nxt[lsu_issue_addr_i] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    // Scoreboard state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    // Stall decode while either source register still awaits its load data.
    always_comb begin
        hazard_o = pend[rs1_addr_i] | pend[rs2_addr_i];
    end

    // Count contention cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            conflict_cnt_o <= '0;
        end else if (ex_wb_valid_i && lsu_wb_valid_i && (conflict_cnt_o != {CNT_W{1'b1}})) begin
            conflict_cnt_o <= conflict_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb/tb_regfile_wb_ctrl.sv - directed self-checking bench for regfile_wb_ctrl
module tb_regfile_wb_ctrl;

    logic        clk;
    logic        rst;
    logic        ex_wb_valid;
    logic [4:0]  ex_wb_addr;
    logic [31:0] ex_wb_data;
    logic        ex_wb_ready;
    logic        lsu_wb_valid;
    logic [4:0]  lsu_wb_addr;
    logic [31:0] lsu_wb_data;
    logic        lsu_wb_ready;
    logic        lsu_issue;
    logic [4:0]  lsu_issue_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        hazard;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [1:0]  conflict_cnt;

    int n_cmp;
    int n_fail;

    regfile_wb_ctrl #(.CNT_W(2)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .ex_wb_valid_i    (ex_wb_valid),
        .ex_wb_addr_i     (ex_wb_addr),
        .ex_wb_data_i     (ex_wb_data),
        .ex_wb_ready_o    (ex_wb_ready),
        .lsu_wb_valid_i   (lsu_wb_valid),
        .lsu_wb_addr_i    (lsu_wb_addr),
        .lsu_wb_data_i    (lsu_wb_data),
        .lsu_wb_ready_o   (lsu_wb_ready),
        .lsu_issue_i      (lsu_issue),
        .lsu_issue_addr_i (lsu_issue_addr),
        .rs1_addr_i       (rs1_addr),
        .rs2_addr_i       (rs2_addr),
        .hazard_o         (hazard),
        .rd_we_o          (rd_we),
        .rd_addr_o        (rd_addr),
        .rd_data_o        (rd_data),
        .conflict_cnt_o   (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1;
        ex_wb_valid = 0; ex_wb_addr = 0; ex_wb_data = 0;
        lsu_wb_valid = 0; lsu_wb_addr = 0; lsu_wb_data = 0;
        lsu_issue = 0; lsu_issue_addr = 0; rs1_addr = 0; rs2_addr = 0;

        #3;
        chk("rst_rd_we", rd_we, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_hazard", hazard, 0);
        chk("rst_cnt", conflict_cnt, 0);
        chk("rst_ex_ready", ex_wb_ready, 0);
        chk("rst_lsu_ready", lsu_wb_ready, 0);
        #4;
        rst = 1'b0;

        // Tie after reset: EX, LSU, EX, then LSU with counter saturated at 3
        ex_wb_valid = 1; ex_wb_addr = 5'd1; ex_wb_data = 32'h000000AA;
        lsu_wb_valid = 1; lsu_wb_addr = 5'd2; lsu_wb_data = 32'h000000BB;
        #1;
        chk("tie1_ex_ready", ex_wb_ready, 1);
        chk("tie1_lsu_ready", lsu_wb_ready, 0);
        step();
        chk("tie1_rd_addr", rd_addr, 1);
        chk("tie1_rd_data", rd_data, 32'hAA);
        chk("tie2_ex_ready", ex_wb_ready, 0);
        chk("tie2_lsu_ready", lsu_wb_ready, 1);
        step();
        chk("tie2_rd_addr", rd_addr, 2);
        chk("tie2_rd_data", rd_data, 32'hBB);
        chk("tie3_ex_ready", ex_wb_ready, 1);
        step();
        chk("tie3_rd_addr", rd_addr, 1);
        chk("tie3_cnt", conflict_cnt, 3);
        chk("tie4_lsu_ready", lsu_wb_ready, 1);
        step();
        chk("tie4_rd_addr", rd_addr, 2);
        chk("cnt_saturated", conflict_cnt, 3);
        ex_wb_valid = 0; lsu_wb_valid = 0;

        // EX only write
        ex_wb_valid = 1; ex_wb_addr = 5'd5; ex_wb_data = 32'h1234;
        #1;
        chk("exonly_ex_ready", ex_wb_ready, 1);
        chk("exonly_lsu_ready", lsu_wb_ready, 0);
        step();
        ex_wb_valid = 0;
        chk("exonly_we", rd_we, 1);
        chk("exonly_addr", rd_addr, 5);
        chk("exonly_data", rd_data, 32'h1234);
        step();
        chk("exonly_we_off", rd_we, 0);
        chk("exonly_addr_hold", rd_addr, 5);
        chk("exonly_data_hold", rd_data, 32'h1234);

        // Scoreboard round trip on x7
        lsu_issue = 1; lsu_issue_addr = 5'd7;
        step();
        lsu_issue = 0; rs1_addr = 5'd7;
        #1;
        chk("sb_hazard_set", hazard, 1);
        lsu_wb_valid = 1; lsu_wb_addr = 5'd7; lsu_wb_data = 32'h77;
        #1;
        chk("sb_lsu_ready", lsu_wb_ready, 1);
        step();
        lsu_wb_valid = 0;
        chk("sb_we", rd_we, 1);
        chk("sb_addr", rd_addr, 7);
        chk("sb_hazard_n", hazard, 1);
        step();
        chk("sb_hazard_clr", hazard, 0);
        rs1_addr = 0;

        // x0 handling
        ex_wb_valid = 1; ex_wb_addr = 5'd0; ex_wb_data = 32'h55;
        #1;
        chk("x0_ex_ready", ex_wb_ready, 1);
        step();
        ex_wb_valid = 0;
        chk("x0_we", rd_we, 0);
        chk("x0_data", rd_data, 32'h55);
        lsu_issue = 1; lsu_issue_addr = 5'd0; rs2_addr = 5'd0;
        step();
        lsu_issue = 0;
        chk("x0_hazard", hazard, 0);

        // Set/clear collision on x9
        lsu_issue = 1; lsu_issue_addr = 5'd9;
        step();
        lsu_issue = 0; rs1_addr = 5'd9;
        lsu_wb_valid = 1; lsu_wb_addr = 5'd9; lsu_wb_data = 32'h99;
        step();
        lsu_wb_valid = 0;
        chk("coll_we", rd_we, 1);
        lsu_issue = 1; lsu_issue_addr = 5'd9;
        step();
        lsu_issue = 0;
        chk("coll_hazard", hazard, 1);
        step();
        chk("coll_hazard_hold", hazard, 1);

        // Async reset mid-stream with pend[9] set and rd_we high
        ex_wb_valid = 1; ex_wb_addr = 5'd3; ex_wb_data = 32'h33;
        step();
        ex_wb_valid = 0;
        chk("pre_rst_we", rd_we, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_we", rd_we, 0);
        chk("arst_addr", rd_addr, 0);
        chk("arst_data", rd_data, 0);
        chk("arst_hazard", hazard, 0);
        chk("arst_cnt", conflict_cnt, 0);
        #1;
        rst = 1'b0;
        ex_wb_valid = 1; ex_wb_addr = 5'd4; ex_wb_data = 32'h44;
        lsu_wb_valid = 1; lsu_wb_addr = 5'd6; lsu_wb_data = 32'h66;
        #1;
        chk("post_rst_ex_ready", ex_wb_ready, 1);
        chk("post_rst_lsu_ready", lsu_wb_ready, 0);
        step();
        ex_wb_valid = 0; lsu_wb_valid = 0;
        chk("post_rst_addr", rd_addr, 4);
        chk("post_rst_hazard", hazard, 0);
        chk("post_rst_cnt", conflict_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
